serial_subtractor: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 18 +
 rtl/full_subtractor_bit.sv | 29 ++
 rtl/serial_subtractor.sv | 144 ++++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding,
// default operand width and the bit-counter width helper.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter must index bits 0..WIDTH-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full-subtractor cell.
// With SERIAL_SUB_ADD_EN defined the cell gains an 'add' input that turns it
// into a full adder (br_in/br_out then carry the carry chain).
module full_subtractor_bit (
   input  logic x,
   input  logic y,
   input  logic br_in,
`ifdef SERIAL_SUB_ADD_EN
   input  logic add,
`endif
   output logic d,
   output logic br_out
);

   // Sum/difference bit is the same XOR in both modes; only the chain differs.
   always_comb begin
      d = x ^ y ^ br_in;
`ifdef SERIAL_SUB_ADD_EN
      if (add) begin
         br_out = (x & y) | (x & br_in) | (y & br_in);
      end else begin
         br_out = (~x & y) | (~(x ^ y) & br_in);
      end
`else
      br_out = (~x & y) | (~(x ^ y) & br_in);
`endif
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - b_in, one bit per clock, LSB first.
// start is sampled only in IDLE; done pulses one cycle, WIDTH clocks after
// the accept edge. Result outputs only change on the RUN->DONE edge.
// Optional macro SERIAL_SUB_ADD_EN adds op_add (full-adder mode).
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
`ifdef SERIAL_SUB_ADD_EN
   input  logic             op_add,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             zero,
   output logic             ovf
);

   localparam int CW = cnt_width(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic             r_br;
`ifdef SERIAL_SUB_ADD_EN
   logic             r_add;
`endif

   logic             w_d;
   logic             w_br;
   logic             w_last;
   logic [WIDTH-1:0] w_res;

   full_subtractor_bit u_cell (
      .x      (r_a[0]),
      .y      (r_b[0]),
      .br_in  (r_br),
`ifdef SERIAL_SUB_ADD_EN
      .add    (r_add),
`endif
      .d      (w_d),
      .br_out (w_br)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));
   assign w_res  = {w_d, r_sh[WIDTH-1:1]};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and status outputs.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, bit-serial shifting and result publication.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_a   <= '0;
         r_b   <= '0;
         r_sh  <= '0;
         r_br  <= 1'b0;
`ifdef SERIAL_SUB_ADD_EN
         r_add <= 1'b0;
`endif
         diff  <= '0;
         b_out <= 1'b0;
         zero  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_br  <= b_in;
                  r_cnt <= '0;
`ifdef SERIAL_SUB_ADD_EN
                  r_add <= op_add;
`endif
               end
            end
            RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_br  <= w_br;
               r_sh  <= w_res;
               r_cnt <= r_cnt + CW'(1);
               // On the MSB, r_br is the borrow into the MSB, so overflow is
               // simply its disagreement with the borrow out.
               if (w_last) begin
                  diff  <= w_res;
                  b_out <= w_br;
                  zero  <= (w_res == '0);
                  ovf   <= r_br ^ w_br;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle-level behavioural model
// using plain integer arithmetic, per-cycle compare, directed literal checks
// and a randomized phase with random start, operand noise and resets.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         b_in = 1'b0;
   logic         op_add = 1'b0;
   logic         busy, done, b_out, zero, ovf;
   logic [W-1:0] diff;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .b_in   (b_in),
`ifdef SERIAL_SUB_ADD_EN
      .op_add (op_add),
`endif
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .b_out  (b_out),
      .zero   (zero),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         ovf;
      logic         zero;
      logic         bout;
      logic [W-1:0] diff;
   } res_t;

   // Reference arithmetic: unsigned result for diff/borrow, signed for ovf.
   function automatic res_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic add);
      res_t   r;
      longint ux, uy, sx, sy, ur, sr;
      ux = longint'(x);
      uy = longint'(y);
      sx = x[W-1] ? ux - (longint'(1) << W) : ux;
      sy = y[W-1] ? uy - (longint'(1) << W) : uy;
      if (add) begin
         ur = ux + uy + longint'(ci);
         sr = sx + sy + longint'(ci);
         r.bout = (ur >= (longint'(1) << W));
      end else begin
         ur = ux - uy - longint'(ci);
         sr = sx - sy - longint'(ci);
         r.bout = (ur < 0);
      end
      r.diff = ur[W-1:0];
      r.zero = (r.diff == '0);
      r.ovf  = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-level model: cycles left in the operation, pending result, outputs.
   int   m_left = 0;
   bit   m_done = 1'b0;
   res_t m_pend = '0;
   res_t m_out  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_out  <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_out  <= m_pend;
         end
      end else if (start) begin
         m_left <= W;
`ifdef SERIAL_SUB_ADD_EN
         m_pend <= ref_op(a, b, b_in, op_add);
`else
         m_pend <= ref_op(a, b, b_in, 1'b0);
`endif
      end
   end

   // Compare DUT against model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy",  32'(busy),  32'(m_left > 0));
         chk("done",  32'(done),  32'(m_done));
         chk("diff",  32'(diff),  32'(m_out.diff));
         chk("b_out", 32'(b_out), 32'(m_out.bout));
         chk("zero",  32'(zero),  32'(m_out.zero));
         chk("ovf",   32'(ovf),   32'(m_out.ovf));
      end
   end

   // Directed operation with literal expectations and latency check.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic tadd, input bit inject,
                        input logic [W-1:0] e_diff, input logic e_bout,
                        input logic e_zero, input logic e_ovf);
      int cyc;
      @(negedge clk);
      a = ta; b = tb_v; b_in = tbin; op_add = tadd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); b_in = 1'($urandom); op_add = 1'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
      cyc = 0;
      while (!done && cyc < 3 * W) begin
         @(negedge clk);
         cyc++;
         if (inject && cyc == 3) begin
            start = 1'b1; a = 8'hAA; b = 8'h55; b_in = 1'b0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("latency", 32'(cyc), 32'(W));
      chk("lit_diff", 32'(diff), 32'(e_diff));
      chk("lit_b_out", 32'(b_out), 32'(e_bout));
      chk("lit_zero", 32'(zero), 32'(e_zero));
      chk("lit_ovf", 32'(ovf), 32'(e_ovf));
      @(negedge clk);
      chk("single_done", 32'(done), 32'd0);
      chk("hold_diff", 32'(diff), 32'(e_diff));
      repeat (2) @(negedge clk);
      chk("no_extra_done", 32'(done), 32'd0);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_flags", 32'({b_out, zero, ovf}), 32'd0);
      mon_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_op(8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      do_op(8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
      do_op(8'h10, 8'h0F, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

      // Abort mid-RUN: outputs clear immediately, no done follows.
      @(negedge clk);
      a = 8'h33; b = 8'h11; b_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_zero", 32'(zero), 32'd0);
      chk("abort_flags", 32'({b_out, ovf}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'h09, 8'h04, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_SUB_ADD_EN
      do_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
`endif

      // Random phase: free-running inputs, sporadic start and resets.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 399) == 0) begin
            #1 rst_n = 1'b0;
         end
         start  = ($urandom_range(0, 3) == 0);
         a      = W'($urandom);
         b      = W'($urandom);
         b_in   = 1'($urandom);
         op_add = 1'($urandom);
      end
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b0;
      repeat (2 * W) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
